// File: rtl/bp_pkg.sv
// Shared encodings and helpers for the dynamic branch-direction predictor.
//   CTR_W      : width of one saturating direction counter
//   SNT..ST    : strongly/weakly not-taken / taken encodings
//   RESET_CTR  : value every counter takes on reset (weakly not-taken)
//   sat_update : next value of a 2-bit saturating counter given the outcome
package bp_pkg;

    localparam int unsigned CTR_W = 2;

    localparam logic [CTR_W-1:0] SNT = 2'b00;
    localparam logic [CTR_W-1:0] WNT = 2'b01;
    localparam logic [CTR_W-1:0] WT  = 2'b10;
    localparam logic [CTR_W-1:0] ST  = 2'b11;

    localparam logic [CTR_W-1:0] RESET_CTR = WNT;

    // Step toward taken/not-taken, sticking at either end.
    function automatic logic [CTR_W-1:0] sat_update(input logic [CTR_W-1:0] ctr,
                                                    input logic             taken);
        logic [CTR_W-1:0] v;
        case (ctr)
            SNT:     v = taken ? WNT : SNT;
            WNT:     v = taken ? WT  : SNT;
            WT:      v = taken ? ST  : WNT;
            default: v = taken ? ST  : WT;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/branch_predict_ctrl_bht_table.sv
// Branch history table: 2**IDX_W two-bit saturating counters.
//   clk, rst_n : clock, asynchronous active-low reset (all entries -> RESET_CTR)
//   i_raddr    : asynchronous read index
//   o_rdata    : counter at i_raddr (pre-update value when also being written)
//   i_we       : train the entry at i_waddr this cycle
//   i_waddr    : training index
//   i_taken    : resolved direction used to step the counter
module bht_table
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [CTR_W-1:0] o_rdata,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic             i_taken
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [CTR_W-1:0] r_ctr [DEPTH];

    // Read-modify-write training port; no read bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_ctr[IDX_W'(i)] <= RESET_CTR;
            end
        end else if (i_we) begin
            r_ctr[i_waddr] <= sat_update(r_ctr[i_waddr], i_taken);
        end
    end

    assign o_rdata = r_ctr[i_raddr];

endmodule

// File: rtl/branch_predict_ctrl.sv
// Dynamic branch-direction controller for the 5-stage pipeline.
// Predicts in Fetch from a table of 2-bit counters, resolves in Decode,
// redirects/flushes on mispredict and trains the table.
//   clk, rst_n  : clock, asynchronous active-low reset
//   PCF         : Fetch PC (table index = PCF[IDX_W+1:2])
//   IsBranchF   : Fetch instruction is a conditional branch
//   StallD      : hazard unit holds F/D
//   FlushD      : external F/D flush
//   Branch_D    : Decode instruction is a branch
//   Equal_D     : Decode comparator result (actual direction)
//   PredTakenF  : Fetch selects predicted target (combinational)
//   PCSrc_D     : redirect to branch target (taken, predicted not-taken)
//   RecoverD    : redirect to PC+4 (not-taken, predicted taken)
//   FlushFD     : squash Fetch instruction on either redirect
//   BranchCnt   : resolved branches (wraps)
//   MispredCnt  : mispredicted branches (wraps)
module branch_predict_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      PCF,
    input  logic             IsBranchF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             Branch_D,
    input  logic             Equal_D,
    output logic             PredTakenF,
    output logic             PCSrc_D,
    output logic             RecoverD,
    output logic             FlushFD,
    output logic [CNT_W-1:0] BranchCnt,
    output logic [CNT_W-1:0] MispredCnt
);

    logic [IDX_W-1:0] w_idx_f;
    logic [CTR_W-1:0] w_ctr_f;
    logic             w_pred_f;
    logic             w_resolve;
    logic             w_pcsrc;
    logic             w_recover;
    logic             w_flush;
    logic             w_unused_pcf;

    logic             r_pred_taken_d;
    logic [IDX_W-1:0] r_idx_d;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    // Fetch lookup: only the word-aligned low PC bits select an entry.
    assign w_idx_f      = PCF[IDX_W+1:2];
    assign w_unused_pcf = ^{PCF[31:IDX_W+2], PCF[1:0]};

    bht_table #(
        .IDX_W (IDX_W)
    ) u_bht (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raddr (w_idx_f),
        .o_rdata (w_ctr_f),
        .i_we    (w_resolve),
        .i_waddr (r_idx_d),
        .i_taken (Equal_D)
    );

    assign w_pred_f = IsBranchF & w_ctr_f[1];

    // Decode resolution is suppressed while stalled so a branch resolves once.
    assign w_resolve = Branch_D & ~StallD;
    assign w_pcsrc   = w_resolve &  Equal_D & ~r_pred_taken_d;
    assign w_recover = w_resolve & ~Equal_D &  r_pred_taken_d;
    assign w_flush   = w_pcsrc | w_recover;

    // F/D copy of the prediction; a flushed slot carries no prediction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pred_taken_d <= 1'b0;
            r_idx_d        <= '0;
        end else if (FlushD | w_flush) begin
            r_pred_taken_d <= 1'b0;
        end else if (!StallD) begin
            r_pred_taken_d <= w_pred_f;
            r_idx_d        <= w_idx_f;
        end
    end

    // Performance counters, free-running modulo 2**CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_resolve) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (w_flush) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            end
        end
    end

    assign PredTakenF = w_pred_f;
    assign PCSrc_D    = w_pcsrc;
    assign RecoverD   = w_recover;
    assign FlushFD    = w_flush;
    assign BranchCnt  = r_branch_cnt;
    assign MispredCnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: hand-derived vector table,
// directed corner sequences and a random phase against a behavioural model.
module tb_branch_predict_ctrl;

    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic [31:0]      PCF;
    logic             IsBranchF;
    logic             StallD;
    logic             FlushD;
    logic             Branch_D;
    logic             Equal_D;
    logic             PredTakenF;
    logic             PCSrc_D;
    logic             RecoverD;
    logic             FlushFD;
    logic [CNT_W-1:0] BranchCnt;
    logic [CNT_W-1:0] MispredCnt;

    branch_predict_ctrl #(
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PCF        (PCF),
        .IsBranchF  (IsBranchF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .Branch_D   (Branch_D),
        .Equal_D    (Equal_D),
        .PredTakenF (PredTakenF),
        .PCSrc_D    (PCSrc_D),
        .RecoverD   (RecoverD),
        .FlushFD    (FlushFD),
        .BranchCnt  (BranchCnt),
        .MispredCnt (MispredCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        ptf;
        logic        pcsrc;
        logic        rec;
        logic        fl;
        logic [15:0] bcnt;
        logic [15:0] mcnt;
    } exp_t;

    typedef struct {
        logic [31:0] pcf;
        logic        isbr;
        logic        stall;
        logic        fld;
        logic        br;
        logic        eq;
        exp_t        exp;
    } vec_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural reference: counters, F/D prediction copy, perf counters.
    logic [1:0]  m_tbl [16];
    logic        m_pred;
    logic [3:0]  m_idx;
    logic [15:0] m_b;
    logic [15:0] m_m;
    logic        m_ptf;
    logic        m_res;
    logic        m_pcsrc;
    logic        m_rec;

    assign m_ptf   = IsBranchF & m_tbl[PCF[5:2]][1];
    assign m_res   = Branch_D & !StallD;
    assign m_pcsrc = m_res & Equal_D & !m_pred;
    assign m_rec   = m_res & !Equal_D & m_pred;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_tbl[i] <= 2'b01;
            m_pred <= 1'b0;
            m_idx  <= 4'd0;
            m_b    <= 16'd0;
            m_m    <= 16'd0;
        end else begin
            if (m_res) begin
                if (Equal_D)
                    m_tbl[m_idx] <= (m_tbl[m_idx] == 2'b11) ? 2'b11 : 2'(m_tbl[m_idx] + 2'd1);
                else
                    m_tbl[m_idx] <= (m_tbl[m_idx] == 2'b00) ? 2'b00 : 2'(m_tbl[m_idx] - 2'd1);
                m_b <= 16'(m_b + 16'd1);
            end
            if (m_pcsrc || m_rec) m_m <= 16'(m_m + 16'd1);
            if (FlushD || m_pcsrc || m_rec) begin
                m_pred <= 1'b0;
            end else if (!StallD) begin
                m_pred <= m_ptf;
                m_idx  <= PCF[5:2];
            end
        end
    end

    function automatic exp_t model_out();
        exp_t e;
        e.ptf   = m_ptf;
        e.pcsrc = m_pcsrc;
        e.rec   = m_rec;
        e.fl    = m_pcsrc | m_rec;
        e.bcnt  = m_b;
        e.mcnt  = m_m;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] pcf, input logic isbr, input logic stall,
                                input logic fld, input logic br, input logic eq,
                                input logic ptf, input logic pcsrc, input logic rec,
                                input logic fl, input logic [15:0] b, input logic [15:0] m);
        vec_t v;
        v.pcf   = pcf;   v.isbr = isbr; v.stall = stall;
        v.fld   = fld;   v.br   = br;   v.eq    = eq;
        v.exp.ptf = ptf; v.exp.pcsrc = pcsrc; v.exp.rec = rec; v.exp.fl = fl;
        v.exp.bcnt = b;  v.exp.mcnt = m;
        return v;
    endfunction

    // Drive one cycle at posedge+1, push expectation, compare on the negedge.
    task automatic apply(input string tag, input vec_t v, input bit use_model);
        exp_t e;
        PCF = v.pcf; IsBranchF = v.isbr; StallD = v.stall;
        FlushD = v.fld; Branch_D = v.br; Equal_D = v.eq;
        #1;
        e = use_model ? model_out() : v.exp;
        q.push_back(e);
        @(negedge clk);
        e = q.pop_front();
        check({tag, ".PredTakenF"}, 32'(PredTakenF), 32'(e.ptf));
        check({tag, ".PCSrc_D"},    32'(PCSrc_D),    32'(e.pcsrc));
        check({tag, ".RecoverD"},   32'(RecoverD),   32'(e.rec));
        check({tag, ".FlushFD"},    32'(FlushFD),    32'(e.fl));
        check({tag, ".BranchCnt"},  32'(BranchCnt),  32'(e.bcnt));
        check({tag, ".MispredCnt"}, 32'(MispredCnt), 32'(e.mcnt));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    vec_t vecs[13];

    initial begin
        // Branch at 0x40 (index 0): learn taken, saturate, then mispredict not-taken.
        vecs[0]  = mk(32'h40,  1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(32'h44,  0, 0, 0, 1, 1,  0, 1, 0, 1, 0, 0);
        vecs[2]  = mk(32'h100, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1);
        vecs[3]  = mk(32'h40,  1, 0, 0, 0, 0,  1, 0, 0, 0, 1, 1);
        vecs[4]  = mk(32'h100, 0, 0, 0, 1, 1,  0, 0, 0, 0, 1, 1);
        vecs[5]  = mk(32'h40,  1, 0, 0, 0, 0,  1, 0, 0, 0, 2, 1);
        vecs[6]  = mk(32'h100, 0, 0, 0, 1, 1,  0, 0, 0, 0, 2, 1);
        vecs[7]  = mk(32'h40,  1, 0, 0, 0, 0,  1, 0, 0, 0, 3, 1);
        vecs[8]  = mk(32'h100, 0, 0, 0, 1, 0,  0, 0, 1, 1, 3, 1);
        vecs[9]  = mk(32'h44,  0, 0, 0, 0, 0,  0, 0, 0, 0, 4, 2);
        vecs[10] = mk(32'h40,  1, 0, 0, 0, 0,  1, 0, 0, 0, 4, 2);
        vecs[11] = mk(32'h100, 0, 0, 0, 1, 1,  0, 0, 0, 0, 4, 2);
        vecs[12] = mk(32'h0,   0, 0, 0, 0, 0,  0, 0, 0, 0, 5, 2);

        rst_n = 1'b0;
        PCF = 32'h40; IsBranchF = 1'b1; StallD = 1'b0;
        FlushD = 1'b0; Branch_D = 1'b0; Equal_D = 1'b0;
        #12;
        check("reset.PredTakenF", 32'(PredTakenF), 32'd0);
        check("reset.PCSrc_D",    32'(PCSrc_D),    32'd0);
        check("reset.RecoverD",   32'(RecoverD),   32'd0);
        check("reset.FlushFD",    32'(FlushFD),    32'd0);
        check("reset.BranchCnt",  32'(BranchCnt),  32'd0);
        check("reset.MispredCnt", 32'(MispredCnt), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) apply($sformatf("vec%0d", i), vecs[i], 1'b0);

        // Stall for three cycles with the branch in Decode, then resolve once.
        apply("stall.fetch", mk(32'h54, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 2), 1'b0);
        for (int i = 0; i < 3; i++)
            apply($sformatf("stall.hold%0d", i), mk(32'h58, 0, 1, 0, 1, 1, 0, 0, 0, 0, 5, 2), 1'b0);
        apply("stall.resolve", mk(32'h58,  0, 0, 0, 1, 1, 0, 1, 0, 1, 5, 2), 1'b0);
        apply("stall.after",   mk(32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 3), 1'b0);

        // Index 3 trained and read in the same cycle: Fetch sees the old value.
        apply("same.fetch", mk(32'h0C, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6, 3), 1'b0);
        apply("same.train", mk(32'h0C, 1, 0, 0, 1, 1, 0, 1, 0, 1, 6, 3), 1'b0);
        apply("same.next",  mk(32'h0C, 1, 0, 0, 0, 0, 1, 0, 0, 0, 7, 4), 1'b0);

        // External flush drops a taken prediction; the following not-taken needs no recovery.
        apply("flush.fetch", mk(32'h40, 1, 0, 1, 0, 0, 1, 0, 0, 0, 7, 4), 1'b0);
        apply("flush.dec",   mk(32'h44, 0, 0, 0, 1, 0, 0, 0, 0, 0, 7, 4), 1'b0);
        apply("flush.refetch", mk(32'h40, 1, 0, 0, 0, 0, 1, 0, 0, 0, 8, 4), 1'b0);

        // Asynchronous reset mid-cycle with index 0 saturated taken.
        check("areset.before.PredTakenF", 32'(PredTakenF), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset.BranchCnt",  32'(BranchCnt),  32'd0);
        check("areset.MispredCnt", 32'(MispredCnt), 32'd0);
        for (int i = 0; i < 4; i++) begin
            PCF = 32'(i * 4 + 32'h40);
            IsBranchF = 1'b1;
            #1;
            check($sformatf("areset.PredTakenF.pc%0d", i), 32'(PredTakenF), 32'd0);
        end
        Branch_D = 1'b1; Equal_D = 1'b0;
        #1;
        check("areset.RecoverD", 32'(RecoverD), 32'd0);
        Branch_D = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic over a few aliasing indices, checked against the model.
        for (int i = 0; i < 300; i++) begin
            vec_t v;
            v = mk({$urandom_range(0, 255), 24'h0} | 32'($urandom_range(0, 5) << 2),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 0);
            apply($sformatf("rand%0d", i), v, 1'b1);
        end

        check("queue.empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
